// File: rtl/latch_gate_pkg.sv
// Shared types, counter width and parameter-range check for the latch gate controller.
package latch_gate_pkg;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic bit params_ok(input int setup_c, input int open_c, input int hold_c);
        return (setup_c >= 0) && (setup_c <= CNT_MAX) &&
               (open_c  >= 1) && (open_c  <= CNT_MAX) &&
               (hold_c  >= 0) && (hold_c  <= CNT_MAX);
    endfunction

endpackage

// File: rtl/latch_gate_if.sv
// Request handshake plus latch-facing outputs; master = requester, slave = controller.
interface latch_gate_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  WR_VALID;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  WR_READY;
    logic [DATA_WIDTH-1:0] D_OUT;
    logic                  G_OUT;
    logic                  BUSY;
    logic                  DONE;

    modport master (
        output WR_VALID, WR_DATA,
        input  WR_READY, D_OUT, G_OUT, BUSY, DONE
    );

    modport slave (
        input  WR_VALID, WR_DATA,
        output WR_READY, D_OUT, G_OUT, BUSY, DONE
    );
endinterface

// File: rtl/latch_gate_timer.sv
// Loadable down-counter shared by all timed FSM states; load wins over decrement.
// Saturates at zero so a stray decrement never wraps.
module latch_gate_timer
    import latch_gate_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/latch_gate_ctrl.sv
// Drives a level latch: D_OUT set on accept, G_OUT opened for OPEN_CYCLES between setup/hold guards.
// Accept to DONE = SETUP+OPEN+HOLD edges after the accept edge; WR_READY only in IDLE, requests held off otherwise.
// LATCH_GATE_READBACK_EN adds Q_IN/MISMATCH: sticky compare of latch Q against D_OUT on DONE.
module latch_gate_ctrl
    import latch_gate_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int OPEN_CYCLES  = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                  C,
    input  logic                  R,
    latch_gate_if.slave           bus
`ifdef LATCH_GATE_READBACK_EN
    ,
    input  logic [DATA_WIDTH-1:0] Q_IN,
    output logic                  MISMATCH
`endif
);

    if (!params_ok(SETUP_CYCLES, OPEN_CYCLES, HOLD_CYCLES)) begin : g_bad_params
        $error("latch_gate_ctrl: SETUP/HOLD must be 0..15 and OPEN 1..15");
    end

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] OPEN_LD  = CNT_W'((OPEN_CYCLES  > 0) ? OPEN_CYCLES  - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYCLES  > 0) ? HOLD_CYCLES  - 1 : 0);

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_d, w_d_nxt;
    logic                  r_g, w_g_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  w_ld, w_dec, w_zero;
    logic [CNT_W-1:0]      w_ld_val;

    latch_gate_timer u_timer (
        .clk        (C),
        .rst_n      (R),
        .i_load     (w_ld),
        .i_load_val (w_ld_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // G_OUT comes straight from a flop with async clear, so reset drops the gate without a clock.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_state <= IDLE;
            r_d     <= '0;
            r_g     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_d     <= w_d_nxt;
            r_g     <= w_g_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_d_nxt     = r_d;
        w_g_nxt     = r_g;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_ld        = 1'b0;
        w_ld_val    = '0;
        w_dec       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.WR_VALID) begin
                    w_d_nxt    = bus.WR_DATA;
                    w_busy_nxt = 1'b1;
                    w_ld       = 1'b1;
                    if (SETUP_CYCLES > 0) begin
                        w_state_nxt = SETUP;
                        w_ld_val    = SETUP_LD;
                    end else begin
                        w_state_nxt = OPEN;
                        w_g_nxt     = 1'b1;
                        w_ld_val    = OPEN_LD;
                    end
                end
            end
            SETUP: begin
                if (w_zero) begin
                    w_state_nxt = OPEN;
                    w_g_nxt     = 1'b1;
                    w_ld        = 1'b1;
                    w_ld_val    = OPEN_LD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            OPEN: begin
                if (w_zero) begin
                    w_g_nxt = 1'b0;
                    if (HOLD_CYCLES > 0) begin
                        w_state_nxt = HOLD;
                        w_ld        = 1'b1;
                        w_ld_val    = HOLD_LD;
                    end else begin
                        w_state_nxt = IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            HOLD: begin
                if (w_zero) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.WR_READY = (r_state == IDLE);
    assign bus.D_OUT    = r_d;
    assign bus.G_OUT    = r_g;
    assign bus.BUSY     = r_busy;
    assign bus.DONE     = r_done;

`ifdef LATCH_GATE_READBACK_EN
    logic r_mismatch;

    // r_d is still the completed word during the DONE cycle, even if a new request is accepted then.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_mismatch <= 1'b0;
        end else if (r_done && (Q_IN != r_d)) begin
            r_mismatch <= 1'b1;
        end
    end

    assign MISMATCH = r_mismatch;
`else
    // Without readback the latch Q is not observed.
`endif

endmodule

// File: tb/tb_latch_gate_ctrl.sv
// Scoreboarded bench: default-parameter DUT (a) and a SETUP=0/OPEN=1/HOLD=0 DUT (b).
module tb_latch_gate_ctrl;

    localparam int S_A = 1, O_A = 2, H_A = 1;
    localparam int LAT_A = S_A + O_A + H_A;
    localparam int LAT_B = 0 + 1 + 0;

    logic C = 1'b0;
    logic R;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [7:0] q_dat[$];
    int         q_edge[$];

    always #5 C = ~C;
    always @(posedge C) cyc <= cyc + 1;

    latch_gate_if #(.DATA_WIDTH(8)) a ();
    latch_gate_if #(.DATA_WIDTH(8)) b ();

`ifdef LATCH_GATE_READBACK_EN
    logic       q_force_en;
    logic [7:0] q_force_val;
    logic [7:0] a_q_in;
    logic       a_mismatch, b_mismatch;
    assign a_q_in = q_force_en ? q_force_val : a.D_OUT;

    latch_gate_ctrl #(.DATA_WIDTH(8), .SETUP_CYCLES(S_A), .OPEN_CYCLES(O_A), .HOLD_CYCLES(H_A))
        u_dut_a (.C(C), .R(R), .bus(a), .Q_IN(a_q_in), .MISMATCH(a_mismatch));
    latch_gate_ctrl #(.DATA_WIDTH(8), .SETUP_CYCLES(0), .OPEN_CYCLES(1), .HOLD_CYCLES(0))
        u_dut_b (.C(C), .R(R), .bus(b), .Q_IN(b.D_OUT), .MISMATCH(b_mismatch));
`else
    latch_gate_ctrl #(.DATA_WIDTH(8), .SETUP_CYCLES(S_A), .OPEN_CYCLES(O_A), .HOLD_CYCLES(H_A))
        u_dut_a (.C(C), .R(R), .bus(a));
    latch_gate_ctrl #(.DATA_WIDTH(8), .SETUP_CYCLES(0), .OPEN_CYCLES(1), .HOLD_CYCLES(0))
        u_dut_b (.C(C), .R(R), .bus(b));
`endif

    task automatic test_reset();
        @(negedge C);
        n_vec++; if (a.G_OUT !== 1'b0)    begin n_err++; $display("FAIL reset_g got=%b exp=0", a.G_OUT); end
        n_vec++; if (a.D_OUT !== 8'h00)   begin n_err++; $display("FAIL reset_d got=%h exp=00", a.D_OUT); end
        n_vec++; if (a.BUSY !== 1'b0)     begin n_err++; $display("FAIL reset_busy got=%b exp=0", a.BUSY); end
        n_vec++; if (a.DONE !== 1'b0)     begin n_err++; $display("FAIL reset_done got=%b exp=0", a.DONE); end
        n_vec++; if (a.WR_READY !== 1'b1) begin n_err++; $display("FAIL reset_rdy got=%b exp=1", a.WR_READY); end
        n_vec++; if (b.G_OUT !== 1'b0)    begin n_err++; $display("FAIL reset_g_b got=%b exp=0", b.G_OUT); end
        R = 1'b1;
    endtask

    task automatic test_single(input logic [7:0] dat);
        int k, rel, ee;
        bit got;
        logic [7:0] ed;
        @(negedge C);
        a.WR_VALID = 1'b1; a.WR_DATA = dat; k = cyc + 1;
        q_dat.push_back(dat); q_edge.push_back(k + LAT_A);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge C);
            rel = cyc - k;
            if (rel == 0) a.WR_VALID = 1'b0;
            n_vec++;
            if (a.G_OUT !== ((rel >= S_A && rel < S_A + O_A) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL single_g rel=%0d got=%b", rel, a.G_OUT);
            end
            n_vec++;
            if (a.D_OUT !== dat) begin n_err++; $display("FAIL single_d rel=%0d got=%h exp=%h", rel, a.D_OUT, dat); end
            n_vec++;
            if (a.WR_READY !== ((rel >= LAT_A) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL single_rdy rel=%0d got=%b", rel, a.WR_READY);
            end
            if (a.DONE === 1'b1) begin
                got = 1'b1;
                n_vec++;
                if (q_dat.size() == 0) begin
                    n_err++; $display("FAIL single_sb unexpected DONE rel=%0d", rel);
                end else begin
                    ed = q_dat.pop_front(); ee = q_edge.pop_front();
                    if (a.D_OUT !== ed || cyc != ee) begin
                        n_err++; $display("FAIL single_done d=%h exp=%h edge=%0d exp=%0d", a.D_OUT, ed, cyc, ee);
                    end
                end
            end
        end
        if (!got) begin n_vec++; n_err++; $display("FAIL single_timeout no DONE for %h", dat); end
    endtask

    task automatic test_back_to_back();
        int k, n_done, gap, ee;
        bit seen_hi, in_gap, gap_checked;
        logic [7:0] ed;
        @(negedge C);
        a.WR_VALID = 1'b1; a.WR_DATA = 8'h11; k = cyc + 1;
        q_dat.push_back(8'h11); q_edge.push_back(k + LAT_A);
        n_done = 0; gap = 0; seen_hi = 0; in_gap = 0; gap_checked = 0;
        for (int i = 0; i < 30 && n_done < 2; i++) begin
            @(negedge C);
            if (a.WR_VALID && a.BUSY) a.WR_VALID = 1'b0;
            if (a.G_OUT === 1'b1) begin
                if (in_gap) begin
                    n_vec++; gap_checked = 1'b1;
                    if (gap != H_A + 1 + S_A) begin n_err++; $display("FAIL b2b_gap got=%0d exp=%0d", gap, H_A + 1 + S_A); end
                end
                seen_hi = 1'b1; in_gap = 1'b0;
            end else if (seen_hi && !gap_checked) begin
                in_gap = 1'b1; gap++;
            end
            if (a.DONE === 1'b1) begin
                n_vec++;
                if (q_dat.size() == 0) begin
                    n_err++; $display("FAIL b2b_sb unexpected DONE");
                end else begin
                    ed = q_dat.pop_front(); ee = q_edge.pop_front();
                    if (a.D_OUT !== ed || cyc != ee) begin
                        n_err++; $display("FAIL b2b_done d=%h exp=%h edge=%0d exp=%0d", a.D_OUT, ed, cyc, ee);
                    end
                end
                n_done++;
                if (n_done == 1) begin
                    n_vec++;
                    if (a.WR_READY !== 1'b1) begin n_err++; $display("FAIL b2b_rdy got=%b exp=1", a.WR_READY); end
                    a.WR_VALID = 1'b1; a.WR_DATA = 8'h3C;
                    q_dat.push_back(8'h3C); q_edge.push_back(cyc + 1 + LAT_A);
                end
            end else begin
                n_vec++;
                if (a.D_OUT !== ((n_done == 0) ? 8'h11 : 8'h3C)) begin
                    n_err++; $display("FAIL b2b_d got=%h n_done=%0d", a.D_OUT, n_done);
                end
            end
        end
        if (n_done != 2) begin n_vec++; n_err++; $display("FAIL b2b_timeout done_pulses=%0d exp=2", n_done); end
        if (!gap_checked) begin n_vec++; n_err++; $display("FAIL b2b_gap_missing got=none exp=%0d", H_A + 1 + S_A); end
    endtask

    task automatic test_data_toggle();
        int n_done, ee;
        logic [7:0] ed;
        @(negedge C);
        a.WR_VALID = 1'b1; a.WR_DATA = 8'h96;
        q_dat.push_back(8'h96); q_edge.push_back(cyc + 1 + LAT_A);
        n_done = 0;
        for (int i = 0; i < 40 && n_done < 2; i++) begin
            @(negedge C);
            if (a.DONE === 1'b1) begin
                n_vec++;
                if (q_dat.size() == 0) begin
                    n_err++; $display("FAIL toggle_sb unexpected DONE");
                end else begin
                    ed = q_dat.pop_front(); ee = q_edge.pop_front();
                    if (a.D_OUT !== ed || cyc != ee) begin
                        n_err++; $display("FAIL toggle_done d=%h exp=%h edge=%0d exp=%0d", a.D_OUT, ed, cyc, ee);
                    end
                end
                n_done++;
                if (n_done == 1) begin
                    a.WR_DATA = 8'h42;
                    q_dat.push_back(8'h42); q_edge.push_back(cyc + 1 + LAT_A);
                end else begin
                    a.WR_VALID = 1'b0;
                end
            end else begin
                n_vec++;
                if (a.D_OUT !== ((n_done == 0) ? 8'h96 : 8'h42)) begin
                    n_err++; $display("FAIL toggle_d got=%h wr_data=%h", a.D_OUT, a.WR_DATA);
                end
                a.WR_DATA = (i % 2 == 0) ? 8'hFF : 8'h00;
            end
        end
        if (n_done != 2) begin n_vec++; n_err++; $display("FAIL toggle_timeout done_pulses=%0d exp=2", n_done); end
    endtask

    task automatic test_fast();
        int k, rel, ee;
        bit got;
        logic [7:0] ed;
        @(negedge C);
        b.WR_VALID = 1'b1; b.WR_DATA = 8'h69; k = cyc + 1;
        q_dat.push_back(8'h69); q_edge.push_back(k + LAT_B);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge C);
            rel = cyc - k;
            if (rel == 0) b.WR_VALID = 1'b0;
            n_vec++;
            if (b.G_OUT !== ((rel == 0) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL fast_g rel=%0d got=%b", rel, b.G_OUT); end
            n_vec++;
            if (b.D_OUT !== 8'h69) begin n_err++; $display("FAIL fast_d rel=%0d got=%h exp=69", rel, b.D_OUT); end
            if (b.DONE === 1'b1) begin
                got = 1'b1;
                n_vec++;
                if (q_dat.size() == 0) begin
                    n_err++; $display("FAIL fast_sb unexpected DONE");
                end else begin
                    ed = q_dat.pop_front(); ee = q_edge.pop_front();
                    if (b.D_OUT !== ed || cyc != ee) begin
                        n_err++; $display("FAIL fast_done d=%h exp=%h edge=%0d exp=%0d", b.D_OUT, ed, cyc, ee);
                    end
                end
            end
        end
        if (!got) begin n_vec++; n_err++; $display("FAIL fast_timeout no DONE"); end
    endtask

    task automatic test_async_reset();
        @(negedge C);
        a.WR_VALID = 1'b1; a.WR_DATA = 8'h77;
        @(negedge C);
        a.WR_VALID = 1'b0;
        repeat (S_A + 1) @(negedge C);
        n_vec++;
        if (a.G_OUT !== 1'b1) begin n_err++; $display("FAIL areset_pre_g got=%b exp=1", a.G_OUT); end
        #2 R = 1'b0;
        #1;
        n_vec++; if (a.G_OUT !== 1'b0) begin n_err++; $display("FAIL areset_g got=%b exp=0", a.G_OUT); end
        n_vec++; if (a.D_OUT !== 8'h00) begin n_err++; $display("FAIL areset_d got=%h exp=00", a.D_OUT); end
        n_vec++; if (a.BUSY !== 1'b0) begin n_err++; $display("FAIL areset_busy got=%b exp=0", a.BUSY); end
        @(negedge C);
        R = 1'b1;
        q_dat.delete(); q_edge.delete();
        repeat (2) begin
            @(negedge C);
            n_vec++;
            if (a.G_OUT !== 1'b0 || a.DONE !== 1'b0 || a.WR_READY !== 1'b1) begin
                n_err++; $display("FAIL areset_resume g=%b done=%b rdy=%b exp=0,0,1", a.G_OUT, a.DONE, a.WR_READY);
            end
        end
        test_single(8'hC3);
    endtask

`ifdef LATCH_GATE_READBACK_EN
    task automatic test_readback();
        @(negedge C);
        n_vec++;
        if (a_mismatch !== 1'b0) begin n_err++; $display("FAIL rb_init got=%b exp=0", a_mismatch); end
        q_force_en = 1'b1; q_force_val = 8'h00;
        test_single(8'h5A);
        @(negedge C);
        n_vec++;
        if (a_mismatch !== 1'b1) begin n_err++; $display("FAIL rb_set got=%b exp=1", a_mismatch); end
        q_force_en = 1'b0;
        test_single(8'h5A);
        @(negedge C);
        n_vec++;
        if (a_mismatch !== 1'b1) begin n_err++; $display("FAIL rb_sticky got=%b exp=1", a_mismatch); end
        n_vec++;
        if (b_mismatch !== 1'b0) begin n_err++; $display("FAIL rb_b got=%b exp=0", b_mismatch); end
    endtask
`endif

    initial begin
        R = 1'b0;
        a.WR_VALID = 1'b0; a.WR_DATA = 8'h00;
        b.WR_VALID = 1'b0; b.WR_DATA = 8'h00;
`ifdef LATCH_GATE_READBACK_EN
        q_force_en = 1'b0; q_force_val = 8'h00;
`endif
        repeat (3) @(negedge C);
        test_reset();
        test_single(8'hA5);
        test_back_to_back();
        test_data_toggle();
        test_fast();
        test_async_reset();
`ifdef LATCH_GATE_READBACK_EN
        test_readback();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
